// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer: ALU codes, opcodes, FSM states
// and the instruction-register field layout.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_NEG   = 4'd4,
        ALU_NOT   = 4'd5,
        ALU_SHR   = 4'd6,
        ALU_SHRA  = 4'd7,
        ALU_SHL   = 4'd8,
        ALU_ROR   = 4'd9,
        ALU_ROL   = 4'd10,
        ALU_MUL   = 4'd11,
        ALU_DIV   = 4'd12,
        ALU_INCPC = 4'd13,
        ALU_NONE  = 4'd14
    } alu_op_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_RRR, CLS_RR, CLS_MULDIV, CLS_ILLEGAL
    } instr_class_e;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Opcode decoder: maps an opcode to its ALU code and execution class.
module instr_decode
    import control_sequencer_pkg::*;
(
    input  logic [4:0]   opcode,
    output alu_op_e      alu_op,
    output instr_class_e iclass
);

    always_comb begin
        alu_op = ALU_NONE;
        iclass = CLS_RRR;
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_SHR:  alu_op = ALU_SHR;
            OP_SHRA: alu_op = ALU_SHRA;
            OP_SHL:  alu_op = ALU_SHL;
            OP_ROR:  alu_op = ALU_ROR;
            OP_ROL:  alu_op = ALU_ROL;
            OP_MUL:  begin alu_op = ALU_MUL; iclass = CLS_MULDIV; end
            OP_DIV:  begin alu_op = ALU_DIV; iclass = CLS_MULDIV; end
            OP_NEG:  begin alu_op = ALU_NEG; iclass = CLS_RR;     end
            OP_NOT:  begin alu_op = ALU_NOT; iclass = CLS_RR;     end
            default: iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore FSM sequencing fetch and execute micro-steps for one instruction
// per start request.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        MDRout,
    output logic        Rout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        read,
    output logic        Rin,
    output logic [3:0]  ALU_operation,
    output logic [3:0]  reg_select,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_e       state, state_nxt;
    alu_op_e      dec_alu;
    instr_class_e dec_cls;

    wire [3:0] ra = IR[RA_MSB:RA_LSB];
    wire [3:0] rb = IR[RB_MSB:RB_LSB];
    wire [3:0] rc = IR[RC_MSB:RC_LSB];

    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[RC_LSB-1:0];

    instr_decode u_decode (
        .opcode (IR[OPC_MSB:OPC_LSB]),
        .alu_op (dec_alu),
        .iclass (dec_cls)
    );

    always_ff @(posedge clock) begin
        if (!clear) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = start ? S_T0 : S_IDLE;
            S_T0:   state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3:   state_nxt = (dec_cls == CLS_ILLEGAL) ? S_DONE : S_T4;
            S_T4:   state_nxt = (dec_cls == CLS_RR) ? S_DONE : S_T5;
            S_T5:   state_nxt = (dec_cls == CLS_MULDIV) ? S_T6 : S_DONE;
            S_T6:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
        Rout  = 1'b0; MARin   = 1'b0; Zin      = 1'b0; PCin   = 1'b0;
        MDRin = 1'b0; IRin    = 1'b0; Yin      = 1'b0; LOin   = 1'b0;
        HIin  = 1'b0; read    = 1'b0; Rin      = 1'b0;
        ALU_operation = ALU_NONE;
        reg_select    = 4'd0;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        illegal = (state == S_DONE) && (dec_cls == CLS_ILLEGAL);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; ALU_operation = ALU_INCPC; end
            S_T1: begin ZLowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (dec_cls)
                    CLS_RRR:    begin Rout = 1'b1; reg_select = rb; Yin = 1'b1; end
                    CLS_RR:     begin Rout = 1'b1; reg_select = rb; ALU_operation = dec_alu; Zin = 1'b1; end
                    CLS_MULDIV: begin Rout = 1'b1; reg_select = ra; Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (dec_cls)
                    CLS_RRR:    begin Rout = 1'b1; reg_select = rc; ALU_operation = dec_alu; Zin = 1'b1; end
                    CLS_RR:     begin ZLowout = 1'b1; Rin = 1'b1; reg_select = ra; end
                    CLS_MULDIV: begin Rout = 1'b1; reg_select = rb; ALU_operation = dec_alu; Zin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                // Multiply/divide park the low half in LO; everything else writes back to Ra.
                if (dec_cls == CLS_MULDIV) begin
                    ZLowout = 1'b1; LOin = 1'b1;
                end else if (dec_cls == CLS_RRR) begin
                    ZLowout = 1'b1; Rin = 1'b1; reg_select = ra;
                end
            end
            S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle output vectors for each
// instruction class, reset behaviour and back-to-back starts.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] IR    = 32'h0;
    logic PCout, ZLowout, ZHighout, MDRout, Rout, MARin, Zin, PCin;
    logic MDRin, IRin, Yin, LOin, HIin, read, Rin, busy, done, illegal;
    logic [3:0] ALU_operation, reg_select;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .IR(IR),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .read(read), .Rin(Rin),
        .ALU_operation(ALU_operation), .reg_select(reg_select),
        .busy(busy), .done(done), .illegal(illegal)
    );

    localparam logic [14:0] S_PCOUT = 15'h4000, S_ZLOW  = 15'h2000, S_ZHIGH = 15'h1000;
    localparam logic [14:0] S_MDROUT = 15'h0800, S_ROUT = 15'h0400, S_MARIN = 15'h0200;
    localparam logic [14:0] S_ZIN   = 15'h0100, S_PCIN  = 15'h0080, S_MDRIN = 15'h0040;
    localparam logic [14:0] S_IRIN  = 15'h0020, S_YIN   = 15'h0010, S_LOIN  = 15'h0008;
    localparam logic [14:0] S_HIIN  = 15'h0004, S_READ  = 15'h0002, S_RIN   = 15'h0001;

    wire [25:0] obs = {PCout, ZLowout, ZHighout, MDRout, Rout, MARin, Zin, PCin,
                       MDRin, IRin, Yin, LOin, HIin, read, Rin,
                       ALU_operation, reg_select, busy, done, illegal};

    function automatic logic [25:0] ev(input logic [14:0] s, input logic [3:0] alu,
                                       input logic [3:0] sel, input logic b,
                                       input logic d, input logic il);
        return {s, alu, sel, b, d, il};
    endfunction

    function automatic logic [25:0] fetch_ev(input int c);
        case (c)
            1:       return ev(S_PCOUT | S_MARIN | S_ZIN, 4'd13, 4'd0, 1'b1, 1'b0, 1'b0);
            2:       return ev(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
            default: return ev(S_MDROUT | S_IRIN, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
        endcase
    endfunction

    localparam logic [25:0] IDLE_V = 26'({15'h0, 4'd14, 4'd0, 3'b000});
    localparam logic [25:0] DONE_V = 26'({15'h0, 4'd14, 4'd0, 3'b110});

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0; start = 1'b1;
        step();
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL reset_vs_start: got %h want %h", obs, IDLE_V);
        end
        start = 1'b0;
        step();
        clear = 1'b1;
        step();
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", obs, IDLE_V);
        end
    endtask

    task automatic test_shra();
        logic [25:0] exp_v [1:8];
        for (int c = 1; c <= 3; c++) exp_v[c] = fetch_ev(c);
        exp_v[4] = ev(S_ROUT | S_YIN, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_v[5] = ev(S_ROUT | S_ZIN, 4'd7, 4'd4, 1'b1, 1'b0, 1'b0);
        exp_v[6] = ev(S_ZLOW | S_RIN, 4'd14, 4'd7, 1'b1, 1'b0, 1'b0);
        exp_v[7] = DONE_V;
        exp_v[8] = IDLE_V;
        IR = 32'h4382_0000; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            start = 1'b0;
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL shra_cycle%0d: got %h want %h", c, obs, exp_v[c]);
            end
        end
    endtask

    task automatic test_mul();
        logic [25:0] exp_v [1:9];
        for (int c = 1; c <= 3; c++) exp_v[c] = fetch_ev(c);
        exp_v[4] = ev(S_ROUT | S_YIN, 4'd14, 4'd3, 1'b1, 1'b0, 1'b0);
        exp_v[5] = ev(S_ROUT | S_ZIN, 4'd11, 4'd1, 1'b1, 1'b0, 1'b0);
        exp_v[6] = ev(S_ZLOW | S_LOIN, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_v[7] = ev(S_ZHIGH | S_HIIN, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_v[8] = DONE_V;
        exp_v[9] = IDLE_V;
        IR = 32'h7988_0000; start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            step();
            start = 1'b0;
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL mul_cycle%0d: got %h want %h", c, obs, exp_v[c]);
            end
        end
    endtask

    task automatic test_neg();
        logic [25:0] exp_v [1:7];
        for (int c = 1; c <= 3; c++) exp_v[c] = fetch_ev(c);
        exp_v[4] = ev(S_ROUT | S_ZIN, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
        exp_v[5] = ev(S_ZLOW | S_RIN, 4'd14, 4'd2, 1'b1, 1'b0, 1'b0);
        exp_v[6] = DONE_V;
        exp_v[7] = IDLE_V;
        IR = 32'h8928_0000; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL neg_cycle%0d: got %h want %h", c, obs, exp_v[c]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [25:0] exp_v [1:6];
        for (int c = 1; c <= 3; c++) exp_v[c] = fetch_ev(c);
        exp_v[4] = ev(15'h0, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
        exp_v[5] = ev(15'h0, 4'd14, 4'd0, 1'b1, 1'b1, 1'b1);
        exp_v[6] = IDLE_V;
        IR = 32'hF800_0000; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
            checks++;
            if (obs !== exp_v[c]) begin
                errors++;
                $display("FAIL illegal_cycle%0d: got %h want %h", c, obs, exp_v[c]);
            end
        end
    endtask

    task automatic test_clear_mid();
        IR = 32'h4382_0000; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
        end
        checks++;
        if (obs !== ev(S_ROUT | S_ZIN, 4'd7, 4'd4, 1'b1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL clear_mid_at_t4: got %h", obs);
        end
        clear = 1'b0;
        step();
        clear = 1'b1;
        checks++;
        if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL clear_mid_idle: got %h want %h", obs, IDLE_V);
        end
        IR = 32'h8928_0000; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            start = 1'b0;
            checks++;
            if (done !== (c == 6) || busy !== (c != 7)) begin
                errors++;
                $display("FAIL clear_restart_cycle%0d: got done=%b busy=%b want done=%b busy=%b",
                         c, done, busy, (c == 6), (c != 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        IR = 32'h8928_0000; start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            checks++;
            if (done !== (c == 6 || c == 13) || busy !== (c != 7 && c != 14)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got done=%b busy=%b want done=%b busy=%b",
                         c, done, busy, (c == 6 || c == 13), (c != 7 && c != 14));
            end
            if (c == 8) begin
                checks++;
                if (obs !== fetch_ev(1)) begin
                    errors++;
                    $display("FAIL b2b_second_t0: got %h want %h", obs, fetch_ev(1));
                end
            end
        end
        start = 1'b0;
        step();
        step();
    endtask

    initial begin
        #1;
        test_reset();
        test_shra();
        test_mul();
        test_neg();
        test_illegal();
        test_clear_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
